// File: rtl/rambus_arbiter.sv
// Two-master round-robin Wishbone arbiter for the shared OpenRAM bus (rambus_wb_*).
// Optional per-strobe ack watchdog enabled by defining RAMBUS_TIMEOUT_EN.
module rambus_arbiter #(
    parameter int unsigned ADDR_W  = 10,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_n,
    input  logic              m0_cyc_i,
    input  logic              m0_stb_i,
    input  logic              m0_we_i,
    input  logic [3:0]        m0_sel_i,
    input  logic [ADDR_W-1:0] m0_adr_i,
    input  logic [DATA_W-1:0] m0_dat_i,
    output logic              m0_ack_o,
    output logic [DATA_W-1:0] m0_dat_o,
    output logic              m0_err_o,
    input  logic              m1_cyc_i,
    input  logic              m1_stb_i,
    input  logic              m1_we_i,
    input  logic [3:0]        m1_sel_i,
    input  logic [ADDR_W-1:0] m1_adr_i,
    input  logic [DATA_W-1:0] m1_dat_i,
    output logic              m1_ack_o,
    output logic [DATA_W-1:0] m1_dat_o,
    output logic              m1_err_o,
    output logic              rambus_wb_clk_o,
    output logic              rambus_wb_rst_o,
    output logic              rambus_wb_cyc_o,
    output logic              rambus_wb_stb_o,
    output logic              rambus_wb_we_o,
    output logic [3:0]        rambus_wb_sel_o,
    output logic [ADDR_W-1:0] rambus_wb_adr_o,
    output logic [DATA_W-1:0] rambus_wb_dat_o,
    input  logic              rambus_wb_ack_i,
    input  logic [DATA_W-1:0] rambus_wb_dat_i,
    output logic [1:0]        grant_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_e;

    state_e state_q, state_d;
    logic   ptr_q, ptr_d;      // master favoured on the next contended grant
    logic   own0, own1;
    logic   expire_c;

    assign own0 = (state_q == OWN0);
    assign own1 = (state_q == OWN1);

    assign rambus_wb_clk_o = wb_clk_i;
    assign rambus_wb_rst_o = ~wb_rst_n;
    assign grant_o         = {own1, own0};

`ifdef RAMBUS_TIMEOUT_EN
    localparam int unsigned CNT_W = 16;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             owner_stb_c;

    assign owner_stb_c = (own0 & m0_stb_i) | (own1 & m1_stb_i);

    // Idle doubles as the clear-on-entry point for the next owner.
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == IDLE || rambus_wb_ack_i) begin
            cnt_d = '0;
        end else if (owner_stb_c) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    assign expire_c = owner_stb_c & ~rambus_wb_ack_i & (cnt_q == CNT_LAST);
`else
    // TIMEOUT only matters when the watchdog is built in.
    logic [15:0] timeout_unused;
    assign timeout_unused = 16'(TIMEOUT);
    assign expire_c       = 1'b0;
`endif

    // Next-state: grant from IDLE, release on cyc drop or watchdog expiry.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            IDLE: begin
                if (m0_cyc_i && m1_cyc_i) begin
                    state_d = ptr_q ? OWN1 : OWN0;
                end else if (m0_cyc_i) begin
                    state_d = OWN0;
                end else if (m1_cyc_i) begin
                    state_d = OWN1;
                end
            end
            OWN0: begin
                if (!m0_cyc_i || expire_c) begin
                    state_d = IDLE;
                    ptr_d   = 1'b1;
                end
            end
            OWN1: begin
                if (!m1_cyc_i || expire_c) begin
                    state_d = IDLE;
                    ptr_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state_q <= IDLE;
            ptr_q   <= 1'b0;
`ifdef RAMBUS_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
`ifdef RAMBUS_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    // Bus mux: only the owner reaches the RAM; everything is zero while idle.
    always_comb begin
        rambus_wb_cyc_o = 1'b0;
        rambus_wb_stb_o = 1'b0;
        rambus_wb_we_o  = 1'b0;
        rambus_wb_sel_o = '0;
        rambus_wb_adr_o = '0;
        rambus_wb_dat_o = '0;
        if (own0) begin
            rambus_wb_cyc_o = m0_cyc_i & ~expire_c;
            rambus_wb_stb_o = m0_stb_i & ~expire_c;
            rambus_wb_we_o  = m0_we_i;
            rambus_wb_sel_o = m0_sel_i;
            rambus_wb_adr_o = m0_adr_i;
            rambus_wb_dat_o = m0_dat_i;
        end else if (own1) begin
            rambus_wb_cyc_o = m1_cyc_i & ~expire_c;
            rambus_wb_stb_o = m1_stb_i & ~expire_c;
            rambus_wb_we_o  = m1_we_i;
            rambus_wb_sel_o = m1_sel_i;
            rambus_wb_adr_o = m1_adr_i;
            rambus_wb_dat_o = m1_dat_i;
        end
    end

    assign m0_ack_o = own0 & rambus_wb_ack_i;
    assign m1_ack_o = own1 & rambus_wb_ack_i;
    assign m0_dat_o = own0 ? rambus_wb_dat_i : '0;
    assign m1_dat_o = own1 ? rambus_wb_dat_i : '0;
    assign m0_err_o = own0 & expire_c;
    assign m1_err_o = own1 & expire_c;

endmodule

// File: tb/tb_rambus_arbiter.sv
// Directed self-checking bench for rambus_arbiter: grant, mux, release, fairness,
// reset and stray-ack behaviour, plus the watchdog when RAMBUS_TIMEOUT_EN is defined.
module tb_rambus_arbiter;

    localparam int unsigned ADDR_W = 10;
    localparam int unsigned DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
    logic [3:0]        m0_sel, m1_sel;
    logic [ADDR_W-1:0] m0_adr, m1_adr;
    logic [DATA_W-1:0] m0_wdat, m1_wdat;
    logic              m0_ack, m1_ack, m0_err, m1_err;
    logic [DATA_W-1:0] m0_rdat, m1_rdat;
    logic              bus_clk, bus_rst, bus_cyc, bus_stb, bus_we;
    logic [3:0]        bus_sel;
    logic [ADDR_W-1:0] bus_adr;
    logic [DATA_W-1:0] bus_wdat;
    logic              ram_ack;
    logic [DATA_W-1:0] ram_dat;
    logic [1:0]        grant;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    rambus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(8)) dut (
        .wb_clk_i(clk), .wb_rst_n(rst_n),
        .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_sel_i(m0_sel),
        .m0_adr_i(m0_adr), .m0_dat_i(m0_wdat), .m0_ack_o(m0_ack), .m0_dat_o(m0_rdat),
        .m0_err_o(m0_err),
        .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_sel_i(m1_sel),
        .m1_adr_i(m1_adr), .m1_dat_i(m1_wdat), .m1_ack_o(m1_ack), .m1_dat_o(m1_rdat),
        .m1_err_o(m1_err),
        .rambus_wb_clk_o(bus_clk), .rambus_wb_rst_o(bus_rst),
        .rambus_wb_cyc_o(bus_cyc), .rambus_wb_stb_o(bus_stb), .rambus_wb_we_o(bus_we),
        .rambus_wb_sel_o(bus_sel), .rambus_wb_adr_o(bus_adr), .rambus_wb_dat_o(bus_wdat),
        .rambus_wb_ack_i(ram_ack), .rambus_wb_dat_i(ram_dat),
        .grant_o(grant)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_masters;
        m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_sel = 4'h0; m0_adr = '0; m0_wdat = '0;
        m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_sel = 4'h0; m1_adr = '0; m1_wdat = '0;
        ram_ack = 0; ram_dat = '0;
    endtask

    task automatic pulse_reset;
        rst_n = 0;
        #1;
        rst_n = 1;
    endtask

    task automatic test_reset;
        rst_n = 0;
        idle_masters();
        m0_cyc = 1; m0_stb = 1; ram_ack = 1;
        #2;
        total++; if (grant !== 2'b00) begin bad++; $display("FAIL reset_grant got=%b want=00", grant); end
        total++; if (bus_rst !== 1'b1) begin bad++; $display("FAIL reset_bus_rst got=%b want=1", bus_rst); end
        total++; if (bus_cyc !== 1'b0 || bus_stb !== 1'b0) begin bad++; $display("FAIL reset_bus_ctl got=%b%b want=00", bus_cyc, bus_stb); end
        total++; if (m0_ack !== 1'b0 || m1_ack !== 1'b0) begin bad++; $display("FAIL reset_acks got=%b%b want=00", m0_ack, m1_ack); end
        tick();
        total++; if (grant !== 2'b00) begin bad++; $display("FAIL reset_hold_grant got=%b want=00", grant); end
        idle_masters();
        @(negedge clk);
        rst_n = 1;
        #1;
        total++; if (bus_rst !== 1'b0) begin bad++; $display("FAIL reset_release_bus_rst got=%b want=0", bus_rst); end
    endtask

    task automatic test_single;
        tick();
        m0_cyc = 1; m0_stb = 1; m0_we = 1; m0_sel = 4'hF; m0_adr = 10'h005; m0_wdat = 32'h12345678;
        #1;
        total++; if (grant !== 2'b00 || bus_cyc !== 1'b0) begin bad++; $display("FAIL single_latency grant=%b cyc=%b want 00/0", grant, bus_cyc); end
        tick();
        total++; if (grant !== 2'b01) begin bad++; $display("FAIL single_grant got=%b want=01", grant); end
        total++; if (bus_adr !== 10'h005 || bus_wdat !== 32'h12345678) begin bad++; $display("FAIL single_bus_adr_dat got=%h/%h want=005/12345678", bus_adr, bus_wdat); end
        total++; if ({bus_cyc, bus_stb, bus_we, bus_sel} !== 7'b111_1111) begin bad++; $display("FAIL single_bus_ctl got=%b want=1111111", {bus_cyc, bus_stb, bus_we, bus_sel}); end
        total++; if (m0_ack !== 1'b0) begin bad++; $display("FAIL single_early_ack got=%b want=0", m0_ack); end
        tick();
        tick();
        ram_ack = 1;
        #1;
        total++; if (m0_ack !== 1'b1 || m1_ack !== 1'b0) begin bad++; $display("FAIL single_ack got=%b%b want m0=1 m1=0", m0_ack, m1_ack); end
        tick();
        ram_ack = 0; m0_cyc = 0; m0_stb = 0;
        #1;
        total++; if (m0_ack !== 1'b0 || bus_cyc !== 1'b0) begin bad++; $display("FAIL single_drop ack=%b cyc=%b want 0/0", m0_ack, bus_cyc); end
        tick();
        total++; if (grant !== 2'b00 || bus_adr !== '0) begin bad++; $display("FAIL single_release grant=%b adr=%h want 00/000", grant, bus_adr); end
        idle_masters();
    endtask

    task automatic test_contention;
        pulse_reset();
        m0_cyc = 1; m0_stb = 1; m0_we = 1; m0_adr = 10'h011; m0_wdat = 32'hAAAA5555;
        m1_cyc = 1; m1_stb = 1; m1_we = 0; m1_adr = 10'h3FF; m1_wdat = 32'h0BADBEEF;
        tick();
        total++; if (grant !== 2'b01) begin bad++; $display("FAIL cont_first got=%b want=01", grant); end
        total++; if (bus_adr !== 10'h011 || bus_wdat !== 32'hAAAA5555) begin bad++; $display("FAIL cont_mux got=%h/%h want=011/aaaa5555", bus_adr, bus_wdat); end
        m0_cyc = 0; m0_stb = 0;
        tick();
        total++; if (grant !== 2'b00 || bus_cyc !== 1'b0) begin bad++; $display("FAIL cont_gap grant=%b cyc=%b want 00/0", grant, bus_cyc); end
        tick();
        total++; if (grant !== 2'b10 || bus_adr !== 10'h3FF) begin bad++; $display("FAIL cont_second grant=%b adr=%h want 10/3ff", grant, bus_adr); end
        ram_ack = 1; ram_dat = 32'hCAFEF00D;
        #1;
        total++; if (m1_rdat !== 32'hCAFEF00D || m1_ack !== 1'b1) begin bad++; $display("FAIL cont_m1_read got=%h ack=%b want=cafef00d ack=1", m1_rdat, m1_ack); end
        total++; if (m0_rdat !== '0 || m0_ack !== 1'b0) begin bad++; $display("FAIL cont_m0_quiet got=%h ack=%b want=0 ack=0", m0_rdat, m0_ack); end
        tick();
        idle_masters();
        tick();
    endtask

    task automatic test_fairness;
        int         grants = 0;
        logic [1:0] exp_g = 2'b01;
        logic [1:0] prev_g = 2'b00;
        logic [1:0] g;
        bit         phase = 0;
        pulse_reset();
        m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
        for (int c = 0; c < 60 && grants < 8; c++) begin
            tick();
            g = grant;
            if (g != 2'b00 && !phase) begin
                total++;
                if (g !== exp_g || prev_g !== 2'b00) begin
                    bad++; $display("FAIL fair_grant%0d got=%b prev=%b want=%b after 00", grants, g, prev_g, exp_g);
                end
                exp_g  = {exp_g[0], exp_g[1]};
                grants++;
                phase   = 1;
                ram_ack = 1;
            end else if (g != 2'b00) begin
                phase   = 0;
                ram_ack = 0;
                if (g == 2'b01) begin m0_cyc = 0; m0_stb = 0; end
                else begin m1_cyc = 0; m1_stb = 0; end
            end else begin
                ram_ack = 0;
                m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
            end
            prev_g = g;
        end
        total++; if (grants != 8) begin bad++; $display("FAIL fair_count got=%0d want=8", grants); end
        idle_masters();
        tick();
        tick();
    endtask

    task automatic test_stray_ack;
        ram_ack = 1; ram_dat = 32'hDEADBEEF;
        #1;
        total++; if (m0_ack !== 1'b0 || m1_ack !== 1'b0) begin bad++; $display("FAIL stray_ack got=%b%b want=00", m0_ack, m1_ack); end
        total++; if (m0_rdat !== '0 || m1_rdat !== '0) begin bad++; $display("FAIL stray_dat got=%h/%h want=0/0", m0_rdat, m1_rdat); end
        tick();
        total++; if (grant !== 2'b00) begin bad++; $display("FAIL stray_state got=%b want=00", grant); end
        ram_ack = 0; ram_dat = '0;
    endtask

    task automatic test_timeout;
        m1_cyc = 1; m1_stb = 1; m1_adr = 10'h123;
        tick();
        total++; if (grant !== 2'b10) begin bad++; $display("FAIL to_grant got=%b want=10", grant); end
`ifdef RAMBUS_TIMEOUT_EN
        for (int k = 1; k <= 8; k++) begin
            total++;
            if (m1_err !== (k == 8)) begin bad++; $display("FAIL to_err_cycle%0d got=%b want=%b", k, m1_err, (k == 8)); end
            if (k == 8) begin
                total++; if (bus_cyc !== 1'b0 || bus_stb !== 1'b0) begin bad++; $display("FAIL to_bus_forced got=%b%b want=00", bus_cyc, bus_stb); end
            end
            tick();
        end
        total++; if (grant !== 2'b00 || m1_err !== 1'b0) begin bad++; $display("FAIL to_idle grant=%b err=%b want 00/0", grant, m1_err); end
        m0_cyc = 1; m0_stb = 1;
        tick();
        total++; if (grant !== 2'b01) begin bad++; $display("FAIL to_next_grant got=%b want=01", grant); end
`else
        for (int k = 1; k <= 12; k++) begin
            total++;
            if (m1_err !== 1'b0 || grant !== 2'b10) begin bad++; $display("FAIL hold_cycle%0d err=%b grant=%b want 0/10", k, m1_err, grant); end
            tick();
        end
`endif
        idle_masters();
        tick();
        tick();
    endtask

    task automatic test_reset_mid;
        m1_cyc = 1; m1_stb = 1; m1_we = 1; m1_sel = 4'h3; m1_adr = 10'h2A5; m1_wdat = 32'h55AA55AA;
        tick();
        total++; if (grant !== 2'b10 || bus_stb !== 1'b1) begin bad++; $display("FAIL mid_own1 grant=%b stb=%b want 10/1", grant, bus_stb); end
        ram_ack = 1;
        #1;
        rst_n = 0;
        #1;
        total++; if (grant !== 2'b00) begin bad++; $display("FAIL mid_grant got=%b want=00", grant); end
        total++; if ({bus_cyc, bus_stb, bus_we, bus_sel} !== 7'b0) begin bad++; $display("FAIL mid_bus_ctl got=%b want=0000000", {bus_cyc, bus_stb, bus_we, bus_sel}); end
        total++; if (bus_adr !== '0 || bus_wdat !== '0) begin bad++; $display("FAIL mid_bus_data got=%h/%h want=0/0", bus_adr, bus_wdat); end
        total++; if (m1_ack !== 1'b0) begin bad++; $display("FAIL mid_ack got=%b want=0", m1_ack); end
        ram_ack = 0;
        m0_cyc = 1; m0_stb = 1;
        #1;
        rst_n = 1;
        tick();
        total++; if (grant !== 2'b01) begin bad++; $display("FAIL mid_first_grant got=%b want=01", grant); end
        idle_masters();
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_fairness();
        test_stray_ack();
        test_timeout();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

endmodule
